// File: rtl/imem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// imem_arbiter_pkg
//
// Purpose : Shared definitions for the instruction-memory arbiter and its
//           round-robin chooser. Holds the FSM state encodings, the requester
//           port ids, the watchdog counter width and the debug view struct
//           that the arbiter exposes for checkers.
//
// Contents:
//   ARB_IDLE / ARB_BUSY / ARB_RESP : arbiter FSM state encodings (2 bits)
//   ARB_P0 / ARB_P1                : requester port ids (port 0 = fetch)
//   ARB_WD_W                       : watchdog counter width (TIMEOUT <= 255)
//   arb_dbg_t                      : packed debug view of the arbiter state
//   arb_other_port()               : helper returning the opposite port id
// -----------------------------------------------------------------------------
package imem_arbiter_pkg;

    // FSM state encodings; kept as plain constants so older tools and
    // waveform viewers see stable numeric values.
    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_BUSY = 2'd1;
    localparam logic [1:0] ARB_RESP = 2'd2;

    // Requester port ids.
    localparam logic ARB_P0 = 1'b0;
    localparam logic ARB_P1 = 1'b1;

    // Watchdog counter width; wide enough for any TIMEOUT in 1..255.
    localparam int ARB_WD_W = 8;

    // Debug view of the arbiter: current state, the port granted most
    // recently (also the port owning the in-flight transaction) and the
    // watchdog count.
    typedef struct packed {
        logic [1:0]          state;
        logic                last_grant;
        logic [ARB_WD_W-1:0] wd_count;
    } arb_dbg_t;

    // Opposite port id; used for the round-robin tie break.
    function automatic logic arb_other_port(input logic port);
        return ~port;
    endfunction

endpackage : imem_arbiter_pkg

// File: rtl/imem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// imem_arbiter_rr_pick2
//
// Purpose : Combinational two-way round-robin chooser. Given two request bits
//           and the id of the most recently granted port, returns which port
//           to grant next and whether any grant is possible at all. Pure
//           combinational so it can be shared by a later data-memory arbiter.
//
// Ports:
//   i_req0   in   1  request from port 0
//   i_req1   in   1  request from port 1
//   i_last   in   1  port id granted most recently
//   o_grant  out  1  port id to grant (meaningful only when o_valid = 1)
//   o_valid  out  1  at least one request present
// -----------------------------------------------------------------------------
module imem_arbiter_rr_pick2
    import imem_arbiter_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last,
    output logic o_grant,
    output logic o_valid
);

    always_comb begin
        o_valid = i_req0 | i_req1;
        o_grant = ARB_P0;
        if (i_req0 && i_req1) begin
            // Tie: the port that did not win last time goes first.
            o_grant = arb_other_port(i_last);
        end else if (i_req1) begin
            o_grant = ARB_P1;
        end
    end

endmodule : imem_arbiter_rr_pick2

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
//
// Purpose : Shares the single instruction-memory port between the minuteCore
//           fetch unit (port 0, read only) and a data/debug requester (port 1,
//           read or write). Round-robin grant, one outstanding transaction,
//           and a watchdog that aborts a transaction whose memory never
//           answers.
//
// Handshake (enable/ready, same protocol imem speaks):
//   A requester raises rN_enable with a stable rN_addr (and for port 1 stable
//   r1_wr/r1_wdata) and holds them until rN_ready. rN_ready is a one-cycle
//   completion pulse; rN_data is valid in that cycle and holds its value until
//   the next completion on that port. Keeping enable high past the pulse is a
//   new request, arbitrated on the next IDLE cycle. Towards memory, mem_enable
//   is held high for the whole BUSY phase with mem_addr/mem_wr/mem_wdata
//   stable; the first cycle with mem_ready high completes the access. mem_ready
//   outside BUSY is ignored.
//
// Ports:
//   clk          in   1       clock, rising edge
//   reset        in   1       synchronous active-high reset
//   r0_addr      in   ADDR_W  fetch address
//   r0_enable    in   1       fetch request
//   r0_data      out  DATA_W  fetch read data
//   r0_ready     out  1       fetch completion pulse
//   r1_addr      in   ADDR_W  data-port address
//   r1_enable    in   1       data-port request
//   r1_wr        in   1       1 = write, 0 = read
//   r1_wdata     in   DATA_W  data-port write data
//   r1_data      out  DATA_W  data-port read data
//   r1_ready     out  1       data-port completion pulse
//   mem_addr     out  ADDR_W  imem address
//   mem_enable   out  1       imem enable
//   mem_wr       out  1       imem write strobe
//   mem_wdata    out  DATA_W  imem write data
//   mem_data     in   DATA_W  imem read data
//   mem_ready    in   1       imem ready
//   timeout_err  out  1       one-cycle pulse when the watchdog aborts
//   dbg          out  struct  FSM state, last grant and watchdog count
// -----------------------------------------------------------------------------
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic              r0_enable,
    output logic [DATA_W-1:0] r0_data,
    output logic              r0_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic              r1_enable,
    input  logic              r1_wr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic [DATA_W-1:0] r1_data,
    output logic              r1_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready,
    output logic              timeout_err,
    output arb_dbg_t          dbg
);

    localparam logic [ARB_WD_W-1:0] WD_LIMIT = ARB_WD_W'(TIMEOUT);

    // FSM and grant bookkeeping.
    logic [1:0]          r_state;
    logic                r_last;     // most recent grant = owner of the transaction
    logic [ARB_WD_W-1:0] r_wd;
    logic                r_to;       // set when the watchdog aborted

    // Latched transaction; memory is driven only from these.
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wr;
    logic [DATA_W-1:0]   r_wdata;

    // Per-port result registers.
    logic [DATA_W-1:0]   r_r0_data;
    logic [DATA_W-1:0]   r_r1_data;

    logic                w_pick;
    logic                w_pick_valid;
    logic                w_busy;
    logic                w_resp;
    logic                w_wd_expired;

    imem_arbiter_rr_pick2 u_pick (
        .i_req0  (r0_enable),
        .i_req1  (r1_enable),
        .i_last  (r_last),
        .o_grant (w_pick),
        .o_valid (w_pick_valid)
    );

    assign w_busy       = (r_state == ARB_BUSY);
    assign w_resp       = (r_state == ARB_RESP);
    assign w_wd_expired = (r_wd == WD_LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ARB_IDLE;
            r_last    <= ARB_P1;     // port 0 wins the first tie
            r_wd      <= '0;
            r_to      <= 1'b0;
            r_addr    <= '0;
            r_wr      <= 1'b0;
            r_wdata   <= '0;
            r_r0_data <= '0;
            r_r1_data <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_valid) begin
                        r_last <= w_pick;
                        r_wd   <= '0;
                        r_to   <= 1'b0;
                        if (w_pick == ARB_P1) begin
                            r_addr  <= r1_addr;
                            r_wr    <= r1_wr;
                            r_wdata <= r1_wdata;
                        end else begin
                            // Fetch port is read only.
                            r_addr  <= r0_addr;
                            r_wr    <= 1'b0;
                            r_wdata <= '0;
                        end
                        r_state <= ARB_BUSY;
                    end
                end

                ARB_BUSY: begin
                    r_wd <= r_wd + 1'b1;
                    if (mem_ready) begin
                        // A ready arriving on the expiry cycle still counts.
                        if (r_last == ARB_P1) begin
                            r_r1_data <= mem_data;
                        end else begin
                            r_r0_data <= mem_data;
                        end
                        r_state <= ARB_RESP;
                    end else if (w_wd_expired) begin
                        // Abort: the owner still gets its ready, with zero data.
                        if (r_last == ARB_P1) begin
                            r_r1_data <= '0;
                        end else begin
                            r_r0_data <= '0;
                        end
                        r_to    <= 1'b1;
                        r_state <= ARB_RESP;
                    end
                end

                ARB_RESP: begin
                    r_wd    <= '0;
                    r_to    <= 1'b0;
                    r_state <= ARB_IDLE;
                end

                default: begin
                    r_wd    <= '0;
                    r_to    <= 1'b0;
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Memory side: enable only in BUSY; write strobe qualified by BUSY so a
    // held write flag never leaks into IDLE/RESP.
    assign mem_enable = w_busy;
    assign mem_addr   = r_addr;
    assign mem_wr     = w_busy & r_wr;
    assign mem_wdata  = r_wdata;

    // Requester side: completion pulses exist only in RESP, for the owner.
    assign r0_ready    = w_resp & (r_last == ARB_P0);
    assign r1_ready    = w_resp & (r_last == ARB_P1);
    assign r0_data     = r_r0_data;
    assign r1_data     = r_r1_data;
    assign timeout_err = w_resp & r_to;

    always_comb begin
        dbg            = '0;
        dbg.state      = r_state;
        dbg.last_grant = r_last;
        dbg.wd_count   = r_wd;
    end

endmodule : imem_arbiter

// File: tb/tb_imem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Directed bench for imem_arbiter with a one-cycle memory model, a transaction
// scoreboard (expected completions and expected memory-bus contents) and a
// final report line.
// -----------------------------------------------------------------------------
module tb_imem_arbiter;
  import imem_arbiter_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [ADDR_W-1:0] r0_addr;
  logic              r0_enable;
  logic [DATA_W-1:0] r0_data;
  logic              r0_ready;
  logic [ADDR_W-1:0] r1_addr;
  logic              r1_enable;
  logic              r1_wr;
  logic [DATA_W-1:0] r1_wdata;
  logic [DATA_W-1:0] r1_data;
  logic              r1_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_enable;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;
  logic              timeout_err;
  arb_dbg_t          dbg;

  imem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .r0_addr     (r0_addr),
    .r0_enable   (r0_enable),
    .r0_data     (r0_data),
    .r0_ready    (r0_ready),
    .r1_addr     (r1_addr),
    .r1_enable   (r1_enable),
    .r1_wr       (r1_wr),
    .r1_wdata    (r1_wdata),
    .r1_data     (r1_data),
    .r1_ready    (r1_ready),
    .mem_addr    (mem_addr),
    .mem_enable  (mem_enable),
    .mem_wr      (mem_wr),
    .mem_wdata   (mem_wdata),
    .mem_data    (mem_data),
    .mem_ready   (mem_ready),
    .timeout_err (timeout_err),
    .dbg         (dbg)
  );

  // ---------------- memory model ----------------
  // Answers one cycle after it sees mem_enable (when mem_ok), writes return 0.
  logic              mem_ok;
  logic              inj_rdy;
  logic              m_rdy;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] arr [0:63];

  assign mem_ready = m_rdy | inj_rdy;
  assign mem_data  = m_data;

  always @(posedge clk) begin
    if (reset) begin
      m_rdy  <= 1'b0;
      m_data <= '0;
      arr[1] <= 32'h1111_1111;
      arr[2] <= 32'h2222_2222;
      arr[4] <= 32'h0050_0093;
    end else if (mem_enable && !m_rdy && mem_ok) begin
      m_rdy <= 1'b1;
      if (mem_wr) begin
        arr[mem_addr[7:2]] <= mem_wdata;
        m_data <= '0;
      end else begin
        m_data <= arr[mem_addr[7:2]];
      end
    end else begin
      m_rdy <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  // exp_q : {timeout, port, data} per expected completion
  // bus_q : {wr, addr, wdata} per expected memory transaction
  logic [33:0] exp_q[$];
  logic [64:0] bus_q[$];
  logic [64:0] cur_bus;
  logic        prev_en;
  int          n_vec;
  int          n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s: unexpected event at %0t", tag, $time);
  endtask

  // Called once per cycle, at the falling edge, from the stimulus process.
  task automatic sample();
    logic [33:0]       e;
    logic [DATA_W-1:0] d;
    check("one_ready", 64'(r0_ready & r1_ready), 64'(0));
    check("ready_vs_en", 64'((r0_ready | r1_ready) & mem_enable), 64'(0));
    if (mem_enable && !prev_en) begin
      if (bus_q.size() == 0) begin
        fail("unexp_mem_txn");
        cur_bus = {mem_wr, mem_addr, mem_wdata};
      end else begin
        cur_bus = bus_q.pop_front();
      end
    end
    if (mem_enable) begin
      check("mem_wr_addr", 64'({mem_wr, mem_addr}), 64'(cur_bus[64:32]));
      check("mem_wdata", 64'(mem_wdata), 64'(cur_bus[31:0]));
    end
    if (r0_ready || r1_ready || timeout_err) begin
      if (exp_q.size() == 0) begin
        fail("unexp_ready");
      end else begin
        e = exp_q.pop_front();
        d = r1_ready ? r1_data : r0_data;
        check("completion", 64'({timeout_err, r1_ready, r0_ready | r1_ready, d}),
              64'({e[33], e[32], 1'b1, e[31:0]}));
      end
    end
    prev_en = mem_enable;
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    sample();
  endtask

  task automatic drain(input int bound, output int cycles);
    cycles = 0;
    while (exp_q.size() != 0 && cycles < bound) begin
      step();
      cycles++;
    end
    check("drain_bound", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic push(input logic to, input logic port, input logic [31:0] data,
                      input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_q.push_back({to, port, data});
    bus_q.push_back({wr, addr, wdata});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    n_vec     = 0;
    n_err     = 0;
    prev_en   = 1'b0;
    cur_bus   = '0;
    reset     = 1'b1;
    r0_enable = 1'b0;
    r0_addr   = '0;
    r1_enable = 1'b0;
    r1_addr   = '0;
    r1_wr     = 1'b0;
    r1_wdata  = '0;
    mem_ok    = 1'b1;
    inj_rdy   = 1'b0;

    // Reset state.
    repeat (3) step();
    check("rst_r0_ready", 64'(r0_ready), 64'(0));
    check("rst_r1_ready", 64'(r1_ready), 64'(0));
    check("rst_mem_enable", 64'(mem_enable), 64'(0));
    check("rst_mem_bus", 64'({mem_wr, mem_addr}), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_timeout", 64'(timeout_err), 64'(0));
    check("rst_data", 64'({r0_data, r1_data}), 64'(0));
    check("rst_state", 64'(dbg.state), 64'(ARB_IDLE));
    check("rst_last", 64'(dbg.last_grant), 64'(ARB_P1));
    check("rst_wd", 64'(dbg.wd_count), 64'(0));

    // Contention from reset release: 0,1,0,1.
    reset     = 1'b0;
    r0_enable = 1'b1;
    r0_addr   = 32'h4;
    r1_enable = 1'b1;
    r1_addr   = 32'h8;
    push(1'b0, ARB_P0, 32'h1111_1111, 1'b0, 32'h4, 32'h0);
    push(1'b0, ARB_P1, 32'h2222_2222, 1'b0, 32'h8, 32'h0);
    push(1'b0, ARB_P0, 32'h1111_1111, 1'b0, 32'h4, 32'h0);
    push(1'b0, ARB_P1, 32'h2222_2222, 1'b0, 32'h8, 32'h0);
    drain(40, cyc);
    r0_enable = 1'b0;
    r1_enable = 1'b0;
    check("contention_cycles", 64'(cyc), 64'(15));
    check("contention_last", 64'(dbg.last_grant), 64'(ARB_P1));

    // Single fetch, minimum latency.
    step();
    r0_enable = 1'b1;
    r0_addr   = 32'h10;
    push(1'b0, ARB_P0, 32'h0050_0093, 1'b0, 32'h10, 32'h0);
    drain(20, cyc);
    r0_enable = 1'b0;
    check("fetch_latency", 64'(cyc), 64'(3));
    repeat (3) step();
    check("r0_data_hold", 64'(r0_data), 64'(32'h0050_0093));
    check("idle_after_fetch", 64'(dbg.state), 64'(ARB_IDLE));

    // Write on port 1; live inputs change and enable drops mid-BUSY.
    r1_enable = 1'b1;
    r1_wr     = 1'b1;
    r1_addr   = 32'h20;
    r1_wdata  = 32'hDEAD_BEEF;
    push(1'b0, ARB_P1, 32'h0, 1'b1, 32'h20, 32'hDEAD_BEEF);
    step();
    check("wr_busy", 64'(dbg.state), 64'(ARB_BUSY));
    r1_enable = 1'b0;
    r1_addr   = 32'h3c;
    r1_wdata  = 32'h0;
    drain(20, cyc);
    check("wr_latency", 64'(cyc), 64'(2));
    r1_wr = 1'b0;
    step();
    r0_enable = 1'b1;
    r0_addr   = 32'h20;
    push(1'b0, ARB_P0, 32'hDEAD_BEEF, 1'b0, 32'h20, 32'h0);
    drain(20, cyc);
    r0_enable = 1'b0;
    check("readback_latency", 64'(cyc), 64'(3));

    // Watchdog timeout.
    mem_ok = 1'b0;
    step();
    r0_enable = 1'b1;
    r0_addr   = 32'h30;
    push(1'b1, ARB_P0, 32'h0, 1'b0, 32'h30, 32'h0);
    drain(40, cyc);
    r0_enable = 1'b0;
    mem_ok    = 1'b1;
    check("timeout_latency", 64'(cyc), 64'(17));
    step();
    check("timeout_pulse_end", 64'(timeout_err), 64'(0));
    check("timeout_data_hold", 64'(r0_data), 64'(0));
    r0_enable = 1'b1;
    r0_addr   = 32'h10;
    push(1'b0, ARB_P0, 32'h0050_0093, 1'b0, 32'h10, 32'h0);
    drain(20, cyc);
    r0_enable = 1'b0;
    check("post_timeout_latency", 64'(cyc), 64'(3));

    // Reset two cycles into BUSY, late ready right after reset.
    mem_ok = 1'b0;
    step();
    r1_enable = 1'b1;
    r1_addr   = 32'h8;
    bus_q.push_back({1'b0, 32'h8, 32'h0});
    step();
    step();
    check("pre_reset_busy", 64'(dbg.state), 64'(ARB_BUSY));
    reset     = 1'b1;
    r1_enable = 1'b0;
    step();
    reset   = 1'b0;
    inj_rdy = 1'b1;
    step();
    inj_rdy = 1'b0;
    check("mid_rst_state", 64'(dbg.state), 64'(ARB_IDLE));
    check("mid_rst_ready", 64'({r0_ready, r1_ready, timeout_err}), 64'(0));
    check("mid_rst_mem", 64'({mem_enable, mem_wr, mem_addr}), 64'(0));
    check("mid_rst_wdata", 64'(mem_wdata), 64'(0));
    check("mid_rst_data", 64'({r0_data, r1_data}), 64'(0));
    step();
    check("mid_rst_state2", 64'(dbg.state), 64'(ARB_IDLE));
    mem_ok    = 1'b1;
    r0_enable = 1'b1;
    r0_addr   = 32'h4;
    r1_enable = 1'b1;
    r1_addr   = 32'h8;
    push(1'b0, ARB_P0, 32'h1111_1111, 1'b0, 32'h4, 32'h0);
    push(1'b0, ARB_P1, 32'h2222_2222, 1'b0, 32'h8, 32'h0);
    drain(30, cyc);
    r0_enable = 1'b0;
    r1_enable = 1'b0;
    check("post_rst_cycles", 64'(cyc), 64'(7));

    // Spurious mem_ready while IDLE.
    step();
    inj_rdy = 1'b1;
    step();
    inj_rdy = 1'b0;
    check("spur_state", 64'(dbg.state), 64'(ARB_IDLE));
    check("spur_data", 64'({r0_data, r1_data}), 64'({32'h1111_1111, 32'h2222_2222}));
    step();
    check("spur_state2", 64'(dbg.state), 64'(ARB_IDLE));
    check("spur_mem_en", 64'(mem_enable), 64'(0));

    // Final report.
    check("exp_q_left", 64'(exp_q.size()), 64'(0));
    check("bus_q_left", 64'(bus_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound.
  initial begin
    #200000;
    $fatal(1, "FAIL global_timeout: bench did not finish in time");
  end

endmodule : tb_imem_arbiter

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Two-requester arbiter that shares the single instruction-memory read/write port between minuteCore instruction fetch (port 0) and a data/debug requester (port 1), e.g. a loader or a future load unit.
- Sits between the requesters and imem.
- Uses the enable/ready handshake that imem already speaks.
- Round-robin grant, one outstanding transaction, watchdog timeout on a missing memory ready.

Parameters:
- ADDR_W, 32, address width (= `ADDR_SIZE+1)
- DATA_W, 32, data width (= `INSTR_SIZE+1)
- TIMEOUT, 15, max cycles granted transaction waits for mem_ready before abort (1..255)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- r0_addr  in  ADDR_W  fetch address
- r0_enable  in  1  fetch request
- r0_data  out  DATA_W  fetch read data
- r0_ready  out  1  fetch completion pulse
- r1_addr  in  ADDR_W  data-port address
- r1_enable  in  1  data-port request
- r1_wr  in  1  1 = write, 0 = read
- r1_wdata  in  DATA_W  write data
- r1_data  out  DATA_W  data-port read data
- r1_ready  out  1  data-port completion pulse
- mem_addr  out  ADDR_W  to imem addr
- mem_enable  out  1  to imem enable
- mem_wr  out  1  to imem write strobe
- mem_wdata  out  DATA_W  to imem write data
- mem_data  in  DATA_W  from imem data
- mem_ready  in  1  from imem ready
- timeout_err  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (sync, on clk edge with reset=1): state IDLE, last_grant=1 (so port 0 wins first tie), all outputs 0, watchdog counter 0.
- States:
  - IDLE: no grant.
  - BUSY: transaction latched, waiting for mem_ready.
  - RESP: one-cycle completion.
- IDLE:
  - Only one enable high: grant it.
  - Both high: grant the port != last_grant.
  - On grant: latch addr/wr/wdata into registers (r0 always wr=0), set last_grant, go BUSY.
  - Neither high: stay IDLE.
- BUSY:
  - mem_enable=1; mem_addr/mem_wr/mem_wdata driven from latched registers only, never from live inputs.
  - Counter increments each cycle.
  - mem_ready=1: latch mem_data to the granted port's data register, go RESP.
  - Counter reaches TIMEOUT with no mem_ready: go RESP with data forced 0 and timeout_err pulsed in RESP.
- RESP:
  - mem_enable=0.
  - Granted port's ready=1 for exactly this cycle, with data valid.
  - Counter cleared; return to IDLE.
- Latency: request seen in IDLE at cycle N -> mem_enable from N+1 -> mem_ready at cycle M -> ready at M+1. Minimum 3 cycles request-to-ready with a 1-cycle memory.
- Requester rules:
  - Hold enable and addr stable until its ready pulse.
  - Drop enable the cycle after ready, or keep it high to request again. Re-request is arbitrated next IDLE cycle.
- Data outputs r0_data/r1_data hold the last completed value until overwritten. Only ready qualifies them.
- mem_ready while IDLE or RESP is ignored; no state change, no output.
- Enable deasserted by requester while BUSY: transaction still completes; ready still pulses.
- Reset mid-BUSY: immediate return to IDLE, outputs 0. A late mem_ready after reset is ignored.
- Never more than one of r0_ready/r1_ready high; never ready and mem_enable high together.
- Fairness: under continuous contention grants alternate 0,1,0,1…

Decomposition:
- Shared defines file (alongside def_params):
  - state encodings ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_RESP=2'd2
  - port ids ARB_P0/ARB_P1
- Optional sub-module rr_pick2: combinational 2-way round-robin chooser from (req0, req1, last_grant) -> grant index, valid. Reusable for a later data-memory arbiter.
- Watchdog counter stays inline.

Test Plan:
- Single fetch: r0_enable=1, r0_addr=0x10, imem returns 0x00500093 one cycle later -> mem_addr=0x10 from cycle after request; r0_ready pulses once with r0_data=0x00500093; r1_ready stays 0.
- Contention: both enables held high from reset release (r0_addr=0x4, r1_addr=0x8) -> grant order 0,1,0,1 over four transactions; mem_addr sequence 0x4,0x8,0x4,0x8.
- Write: r1_enable=1, r1_wr=1, r1_addr=0x20, r1_wdata=0xDEADBEEF -> mem_wr=1 and mem_wdata=0xDEADBEEF for the whole BUSY phase; subsequent r0 read of 0x20 returns 0xDEADBEEF.
- Timeout: memory model never asserts ready, TIMEOUT=15 -> timeout_err and r0_ready pulse together 16 cycles after mem_enable rises; r0_data=0; next request is serviced normally.
- Reset mid-transaction: assert reset 2 cycles into BUSY, memory ready arrives the cycle after reset -> all outputs 0, no ready pulse, state IDLE; first post-reset contention grants port 0.
- Spurious ready: pulse mem_ready while IDLE -> no ready outputs, no state change.
